can_error_frame_gen: RTL and testbench

- Downstream consumer of the per-field error detectors: Form, CRC, Stuff, Bit and ACK error blocks.
- On any detected error, takes over TX and sequences a CAN error frame: error flag, superposition wait, error delimiter, then intermission.
- When the sequence finishes, pulses a frame-reset strobe that returns the decoder and the error detectors to start-of-frame hunting.
- Clocked on the bit sample-point strobe, so one clock equals one bit time.

---
 rtl/can_error_frame_gen.sv | 187 ++++++++++++++++++
 tb/tb_can_error_frame_gen.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/can_error_frame_gen.sv
// can_error_frame_gen
//   Takes over the CAN transmit line when any per-field error detector fires.
//   It then sequences a complete error frame: the error flag, the
//   superposition wait, the error delimiter and the intermission.
//   At the end it pulses Frame_Reset so the decoder and the detectors resume
//   hunting for start-of-frame.
//   The clock is the bit sample-point strobe, so one clock is one bit time.
//
// Ports
//   SP           in   sample-point clock (rising edge)
//   reset        in   asynchronous reset, active-low
//   RX           in   sampled bus level, 0 = dominant
//   FORM_Error   in   form error, active-low
//   CRC_Error    in   CRC error, active-low
//   STUFF_Error  in   stuff error, active-low
//   BIT_Error    in   bit error, active-low
//   ACK_Error    in   ACK error, active-low
//   ERR_PASSIVE  in   1 = node is error-passive (recessive flag)
//   TX           out  transmit level, 1 = recessive
//   ERR_Active   out  high while an error frame is in progress
//   Error_Code   out  {FORM,CRC,STUFF,BIT,ACK} captured at detection, active-low
//   Err_Count    out  (CAN_ERR_COUNT_EN only) saturating count of flag starts
//   Frame_Reset  out  active-low one-bit pulse at end of intermission
//   Flag_Restart out  active-high one-bit pulse when the flag is restarted
//
// Optional feature: define CAN_ERR_COUNT_EN to add the 8-bit Err_Count output.

module can_error_frame_gen #(
  parameter int FLAG_LEN  = 6,
  parameter int SUPER_MAX = 7,
  parameter int DELIM_LEN = 8,
  parameter int INTER_LEN = 3,
  parameter int CNT_W     = 4
) (
  input  logic       SP,
  input  logic       reset,
  input  logic       RX,
  input  logic       FORM_Error,
  input  logic       CRC_Error,
  input  logic       STUFF_Error,
  input  logic       BIT_Error,
  input  logic       ACK_Error,
  input  logic       ERR_PASSIVE,
  output logic       TX,
  output logic       ERR_Active,
  output logic [4:0] Error_Code,
`ifdef CAN_ERR_COUNT_EN
  output logic [7:0] Err_Count,
`endif
  output logic       Frame_Reset,
  output logic       Flag_Restart
);

  typedef enum logic [2:0] {IDLE, FLAG, SUPER, DELIM, INTER} state_t;

  localparam logic [CNT_W-1:0] FLAG_LAST  = CNT_W'(FLAG_LEN);
  localparam logic [CNT_W-1:0] SUPER_LAST = CNT_W'(SUPER_MAX - 1);
  localparam logic [CNT_W-1:0] DELIM_LAST = CNT_W'(DELIM_LEN - 1);
  localparam logic [CNT_W-1:0] INTER_LAST = CNT_W'(INTER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             flag_val, flag_val_nxt;
  logic             tx_nxt;
  logic [4:0]       code_nxt;
  logic             frame_reset_nxt;
  logic             restart;
  logic [4:0]       err_vec;
  logic             err;

  assign err_vec = {FORM_Error, CRC_Error, STUFF_Error, BIT_Error, ACK_Error};
  assign err     = ~&err_vec;

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    flag_val_nxt    = flag_val;
    tx_nxt          = 1'b1;
    code_nxt        = Error_Code;
    frame_reset_nxt = 1'b1;
    restart         = 1'b0;

    case (state)
      IDLE: begin
        if (err) begin
          code_nxt     = err_vec;
          // The new flag level goes straight to TX so the flag starts in
          // the very next bit time.
          flag_val_nxt = ERR_PASSIVE;
          tx_nxt       = ERR_PASSIVE;
          cnt_nxt      = CNT_ONE;
          state_nxt    = FLAG;
        end
      end
      FLAG: begin
        tx_nxt = flag_val;
        if (cnt == FLAG_LAST) begin
          tx_nxt    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = SUPER;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      SUPER: begin
        // The first recessive bit after other nodes' flags is already
        // delimiter bit 1.
        if (RX) begin
          cnt_nxt   = CNT_ONE;
          state_nxt = DELIM;
        end else if (cnt == SUPER_LAST) begin
          restart = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      DELIM: begin
        if (!RX) begin
          restart = 1'b1;
        end else if (cnt == DELIM_LAST) begin
          cnt_nxt   = '0;
          state_nxt = INTER;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      INTER: begin
        if (cnt == INTER_LAST) begin
          frame_reset_nxt = 1'b0;
          cnt_nxt         = '0;
          state_nxt       = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase

    // A restart keeps the originally captured Error_Code.
    if (restart) begin
      flag_val_nxt = ERR_PASSIVE;
      tx_nxt       = ERR_PASSIVE;
      cnt_nxt      = CNT_ONE;
      state_nxt    = FLAG;
    end
  end

  always_ff @(posedge SP or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      flag_val     <= 1'b1;
      TX           <= 1'b1;
      ERR_Active   <= 1'b0;
      Error_Code   <= 5'b11111;
      Frame_Reset  <= 1'b1;
      Flag_Restart <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      flag_val     <= flag_val_nxt;
      TX           <= tx_nxt;
      ERR_Active   <= (state_nxt != IDLE);
      Error_Code   <= code_nxt;
      Frame_Reset  <= frame_reset_nxt;
      Flag_Restart <= restart;
    end
  end

`ifdef CAN_ERR_COUNT_EN
  logic count_inc;
  assign count_inc = ((state == IDLE) && err) || restart;

  always_ff @(posedge SP or negedge reset) begin
    if (!reset) begin
      Err_Count <= 8'd0;
    end else if (count_inc && (Err_Count != 8'hFF)) begin
      Err_Count <= Err_Count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_can_error_frame_gen.sv
// Directed bench for can_error_frame_gen. Each error-frame scenario is
// described by the bit index of the flag restart and of the Frame_Reset
// pulse. The expected per-bit values of {TX, ERR_Active, Frame_Reset,
// Flag_Restart} follow from those indices.

module tb_can_error_frame_gen;

  logic       SP = 1'b0;
  logic       reset;
  logic       RX;
  logic       FORM_Error, CRC_Error, STUFF_Error, BIT_Error, ACK_Error;
  logic       ERR_PASSIVE;
  logic       TX;
  logic       ERR_Active;
  logic [4:0] Error_Code;
  logic       Frame_Reset;
  logic       Flag_Restart;
`ifdef CAN_ERR_COUNT_EN
  logic [7:0] Err_Count;
`endif

  int ntest = 0;
  int nfail = 0;

  can_error_frame_gen dut (
    .SP          (SP),
    .reset       (reset),
    .RX          (RX),
    .FORM_Error  (FORM_Error),
    .CRC_Error   (CRC_Error),
    .STUFF_Error (STUFF_Error),
    .BIT_Error   (BIT_Error),
    .ACK_Error   (ACK_Error),
    .ERR_PASSIVE (ERR_PASSIVE),
    .TX          (TX),
    .ERR_Active  (ERR_Active),
    .Error_Code  (Error_Code),
`ifdef CAN_ERR_COUNT_EN
    .Err_Count   (Err_Count),
`endif
    .Frame_Reset (Frame_Reset),
    .Flag_Restart(Flag_Restart)
  );

  always #5 SP = ~SP;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntest++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_errs(input logic [4:0] v);
    {FORM_Error, CRC_Error, STUFF_Error, BIT_Error, ACK_Error} = v;
  endtask

  // Called at a falling edge with the DUT idle.
  //   code   : error inputs applied, active-low
  //   hold   : number of rising edges that see the error inputs low
  //   rx_lo/hi : bit indices where RX is forced dominant (else RX follows TX)
  //   rst_k  : bit index of the Flag_Restart pulse (-1 when there is none)
  //   fr_k   : bit index of the Frame_Reset pulse
  // Bit index k is the bit time that follows the k-th rising edge after
  // detection.
  task automatic run_seq(input string tag, input logic [4:0] code, input int hold,
                         input logic passive, input int rx_lo, input int rx_hi,
                         input int rst_k, input int fr_k);
    logic in_flag;
    logic [3:0] exp_v;
    set_errs(code);
    ERR_PASSIVE = passive;
    for (int k = 0; k <= fr_k + 1; k++) begin
      @(posedge SP);
      @(negedge SP);
      if (k + 1 >= hold) set_errs(5'b11111);
      if (k == 0) chk({tag, "_code"}, 32'(Error_Code), 32'(code));
      in_flag = (k < 6) || (rst_k >= 0 && k >= rst_k && k < rst_k + 6);
      exp_v = {(in_flag ? passive : 1'b1), (k < fr_k), (k != fr_k), (k == rst_k)};
      chk($sformatf("%s_bit%0d", tag, k), 32'({TX, ERR_Active, Frame_Reset, Flag_Restart}),
          32'(exp_v));
      RX = (k >= rx_lo && k <= rx_hi) ? 1'b0 : TX;
    end
    chk({tag, "_code_end"}, 32'(Error_Code), 32'(code));
  endtask

  initial begin
    reset = 1'b0;
    RX = 1'b1;
    ERR_PASSIVE = 1'b0;
    set_errs(5'b11111);

    #12;
    chk("rst_state", 32'({TX, ERR_Active, Frame_Reset, Flag_Restart}), 32'(4'b1010));
    chk("rst_code", 32'(Error_Code), 32'(5'b11111));
    @(negedge SP);
    reset = 1'b1;
    repeat (2) @(negedge SP);
    chk("idle_quiet", 32'({TX, ERR_Active, Frame_Reset, Flag_Restart}), 32'(4'b1010));

    // Error-active flag on a form error.
    run_seq("active", 5'b01111, 1, 1'b0, -1, -1, -1, 17);
    // Error-passive flag on a CRC error.
    run_seq("passive", 5'b10111, 1, 1'b1, -1, -1, -1, 17);
    // Other nodes' flags overlap by 3 bits; the sequence stretches by 3.
    run_seq("super3", 5'b11110, 1, 1'b0, 6, 8, -1, 20);
    // Dominant bit at delimiter bit 4 forces a new flag.
    run_seq("delim_err", 5'b11101, 1, 1'b0, 9, 9, 10, 27);
    // Seven dominant bits after the flag force a new flag.
    run_seq("super_max", 5'b01111, 1, 1'b0, 6, 12, 13, 30);
    // Two simultaneous errors held low for 3 bits: one sequence only.
    run_seq("multi", 5'b11001, 3, 1'b0, -1, -1, -1, 17);
    repeat (3) @(negedge SP);
    chk("multi_after", 32'({TX, ERR_Active, Frame_Reset, Flag_Restart}), 32'(4'b1010));

    // Asynchronous reset in the middle of the flag.
    ERR_PASSIVE = 1'b0;
    set_errs(5'b10111);
    @(negedge SP);
    set_errs(5'b11111);
    repeat (2) @(negedge SP);
    chk("midflag_tx", 32'(TX), 32'(0));
    #2 reset = 1'b0;
    #1;
    chk("async_rst", 32'({TX, ERR_Active, Frame_Reset, Flag_Restart}), 32'(4'b1010));
    chk("async_rst_code", 32'(Error_Code), 32'(5'b11111));
    @(negedge SP);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge SP);
      chk($sformatf("post_rst%0d", k), 32'({TX, ERR_Active, Frame_Reset, Flag_Restart}),
          32'(4'b1010));
    end

`ifdef CAN_ERR_COUNT_EN
    @(negedge SP);
    reset = 1'b0;
    @(negedge SP);
    reset = 1'b1;
    chk("cnt_rst", 32'(Err_Count), 32'(0));
    for (int n = 0; n < 300; n++) begin
      set_errs(5'b11110);
      @(negedge SP);
      set_errs(5'b11111);
      repeat (18) @(negedge SP);
      if (n == 0) chk("cnt_one", 32'(Err_Count), 32'(1));
    end
    chk("cnt_sat", 32'(Err_Count), 32'(255));
`endif

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
